// File: rtl/cdc_bus_rx_mux.sv
// Receive-side terminator for toggle-handshake bus crossings. Synchronises each
// channel's toggle, captures its word and merges all channels round-robin onto one stream.
module cdc_bus_rx_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 3,
  localparam int CHW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       src_toggle,
  input  logic [CHANNELS*WIDTH-1:0] src_bus,
  output logic [CHANNELS-1:0]       src_ack,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [CHW-1:0]            out_chan,
  output logic [CHANNELS-1:0]       overrun,
  input  logic                      overrun_clr
);

  // Handshake: a word moves on any cycle with out_valid && out_ready; while
  // out_valid is high and out_ready low, out_valid/out_data/out_chan hold.

  logic [CHANNELS-1:0] sync_q [DEPTH];
  logic [CHANNELS-1:0] sync_d [DEPTH];

  logic [CHANNELS-1:0] seen_q,     seen_d;
  logic [CHANNELS-1:0] pending_q,  pending_d;
  logic [CHANNELS-1:0] slot_tog_q, slot_tog_d;
  logic [WIDTH-1:0]    slot_q [CHANNELS];
  logic [WIDTH-1:0]    slot_d [CHANNELS];
  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_data_q,  out_data_d;
  logic [CHW-1:0]      out_chan_q,  out_chan_d;
  logic                out_tog_q,   out_tog_d;
  logic [CHANNELS-1:0] src_ack_q,   src_ack_d;
  logic [CHANNELS-1:0] overrun_q,   overrun_d;
  logic [CHW-1:0]      ptr_q,       ptr_d;

  logic [CHANNELS-1:0] sync_last;
  logic [CHANNELS-1:0] ev;
  logic [CHANNELS-1:0] moved;
  logic                load;
  logic                do_move;
  logic                hi_hit;
  logic                lo_hit;
  int                  hi_win;
  int                  lo_win;
  int                  win_i;

  assign sync_last = sync_q[DEPTH-1];
  assign ev        = sync_last ^ seen_q;

  always_comb begin
    sync_d[0] = src_toggle;
    for (int s = 1; s < DEPTH; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  // Round-robin: prefer the lowest pending channel at or above ptr, else wrap to the lowest.
  always_comb begin
    hi_hit = 1'b0;
    lo_hit = 1'b0;
    hi_win = 0;
    lo_win = 0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (pending_q[c]) begin
        lo_hit = 1'b1;
        lo_win = c;
        if (c >= int'(ptr_q)) begin
          hi_hit = 1'b1;
          hi_win = c;
        end
      end
    end
    win_i   = hi_hit ? hi_win : lo_win;
    load    = !out_valid_q || out_ready;
    do_move = load && lo_hit;
  end

  always_comb begin
    seen_d      = seen_q;
    pending_d   = pending_q;
    slot_tog_d  = slot_tog_q;
    slot_d      = slot_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_tog_d   = out_tog_q;
    src_ack_d   = src_ack_q;
    overrun_d   = overrun_clr ? '0 : overrun_q;
    ptr_d       = ptr_q;
    moved       = '0;

    // The ack is a level copy of the accepted toggle, so a resynchronised source recovers.
    if (out_valid_q && out_ready) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (out_chan_q == CHW'(c)) src_ack_d[c] = out_tog_q;
      end
    end

    if (do_move) begin
      out_valid_d = 1'b1;
      out_chan_d  = CHW'(win_i);
      ptr_d       = (win_i + 1 >= CHANNELS) ? '0 : CHW'(win_i + 1);
      for (int c = 0; c < CHANNELS; c++) begin
        if (win_i == c) begin
          moved[c]     = 1'b1;
          out_data_d   = slot_q[c];
          out_tog_d    = slot_tog_q[c];
          pending_d[c] = 1'b0;
        end
      end
    end else if (load) begin
      out_valid_d = 1'b0;
    end

    // An event landing on a channel that is moving this cycle refills the slot cleanly.
    for (int c = 0; c < CHANNELS; c++) begin
      if (ev[c]) begin
        seen_d[c]     = sync_last[c];
        slot_d[c]     = src_bus[c*WIDTH +: WIDTH];
        slot_tog_d[c] = sync_last[c];
        if (pending_q[c] && !moved[c]) overrun_d[c] = 1'b1;
        pending_d[c]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < DEPTH; s++) sync_q[s] <= '0;
      for (int c = 0; c < CHANNELS; c++) slot_q[c] <= '0;
      seen_q      <= '0;
      pending_q   <= '0;
      slot_tog_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_tog_q   <= 1'b0;
      src_ack_q   <= '0;
      overrun_q   <= '0;
      ptr_q       <= '0;
    end else begin
      for (int s = 0; s < DEPTH; s++) sync_q[s] <= sync_d[s];
      for (int c = 0; c < CHANNELS; c++) slot_q[c] <= slot_d[c];
      seen_q      <= seen_d;
      pending_q   <= pending_d;
      slot_tog_q  <= slot_tog_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_tog_q   <= out_tog_d;
      src_ack_q   <= src_ack_d;
      overrun_q   <= overrun_d;
      ptr_q       <= ptr_d;
    end
  end

  assign src_ack   = src_ack_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_cdc_bus_rx_mux.sv
// Directed and random checks for cdc_bus_rx_mux: four 8-bit channels, 3-flop synchronisers.
module tb_cdc_bus_rx_mux;

  localparam int W   = 8;
  localparam int CH  = 4;
  localparam int CHW = 2;
  localparam int EW  = CHW + W;

  logic            clk;
  logic            rst_n;
  logic [CH-1:0]   src_toggle;
  logic [CH*W-1:0] src_bus;
  logic [CH-1:0]   src_ack;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic [CHW-1:0]  out_chan;
  logic [CH-1:0]   overrun;
  logic            overrun_clr;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int mon_idx;
  int any_valid;

  // Scoreboard entries are {channel, data}; per-channel order is preserved by first-match search.
  logic [EW-1:0] exp_q[$];

  cdc_bus_rx_mux #(.WIDTH(W), .CHANNELS(CH), .DEPTH(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src_toggle  (src_toggle),
    .src_bus     (src_bus),
    .src_ack     (src_ack),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_chan    (out_chan),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Source driver: hold the word, flip the toggle, optionally expect delivery.
  task automatic send(input int ch, input logic [W-1:0] d, input bit push);
    src_bus[ch*W +: W] = d;
    src_toggle[ch]     = ~src_toggle[ch];
    if (push) exp_q.push_back({CHW'(ch), d});
  endtask

  // Scoreboard: every accepted word must match the oldest expected word of its channel.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      mon_idx = -1;
      for (int i = 0; i < exp_q.size(); i++) begin
        if (exp_q[i][EW-1:W] == out_chan) begin
          mon_idx = i;
          break;
        end
      end
      if (mon_idx < 0) begin
        check("mon_unexpected_word", {24'h0, out_data}, 32'hFFFF_FFFF);
      end else begin
        check("mon_data", {24'h0, out_data}, {24'h0, exp_q[mon_idx][W-1:0]});
        exp_q.delete(mon_idx);
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    src_toggle  = '0;
    src_bus     = '0;
    out_ready   = 1'b0;
    overrun_clr = 1'b0;
    step(2);
    check("rst_valid", out_valid, 0);
    check("rst_ack", src_ack, 0);
    check("rst_overrun", overrun, 0);
    check("rst_data", out_data, 0);
    rst_n = 1'b1;
    step(1);

    // Single word: visible at edge 5 after the flip, ack one edge after accept
    send(0, 8'hA5, 1'b1);
    step(4);
    check("sw_valid_early", out_valid, 0);
    step(1);
    check("sw_valid", out_valid, 1);
    check("sw_data", out_data, 32'hA5);
    check("sw_chan", out_chan, 0);
    check("sw_ack_before", src_ack, 0);
    out_ready = 1'b1;
    step(1);
    check("sw_ack", src_ack, 32'h1);
    check("sw_valid_drop", out_valid, 0);

    // Reset in the middle of an in-flight toggle
    send(1, 8'h77, 1'b0);
    step(2);
    rst_n      = 1'b0;
    src_toggle = '0;
    src_bus    = '0;
    #1;
    check("mid_rst_ack", src_ack, 0);
    check("mid_rst_valid", out_valid, 0);
    step(2);
    rst_n = 1'b1;
    any_valid = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (out_valid) any_valid = 1;
    end
    check("mid_rst_quiet", any_valid, 0);

    // Round-robin burst from ptr 0
    out_ready = 1'b1;
    for (int c = 0; c < CH; c++) send(c, W'(8'h10 + c), 1'b1);
    step(5);
    check("rr_chan0", out_chan, 0);
    step(1);
    check("rr_chan1", out_chan, 1);
    step(1);
    check("rr_chan2", out_chan, 2);
    step(1);
    check("rr_chan3", out_chan, 3);
    step(1);
    check("rr_idle", out_valid, 0);
    check("rr_ack", src_ack, 32'hF);

    // Channel 2 first moves ptr to 3, so the rest come out 3,0,1
    send(2, 8'h22, 1'b1);
    step(1);
    send(0, 8'h20, 1'b1);
    send(1, 8'h21, 1'b1);
    send(3, 8'h23, 1'b1);
    step(4);
    check("ptr_chan_a", out_chan, 2);
    step(1);
    check("ptr_chan_b", out_chan, 3);
    step(1);
    check("ptr_chan_c", out_chan, 0);
    step(1);
    check("ptr_chan_d", out_chan, 1);
    step(1);
    check("ptr_idle", out_valid, 0);
    check("ptr_ack", src_ack, 0);

    // Backpressure: channel 1 frozen on the output, channel 2 waiting
    out_ready = 1'b0;
    send(1, 8'h51, 1'b1);
    step(1);
    send(2, 8'h52, 1'b1);
    step(4);
    check("bp_valid", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("bp_hold_chan", out_chan, 1);
      check("bp_hold_data", out_data, 32'h51);
    end
    check("bp_ack_held", src_ack, 0);
    out_ready = 1'b1;
    step(1);
    check("bp_next_chan", out_chan, 2);
    check("bp_ack1", src_ack, 32'h2);
    step(1);
    check("bp_idle", out_valid, 0);
    check("bp_ack2", src_ack, 32'h6);

    // Overrun: second word on channel 2 while its first is still pending
    out_ready = 1'b0;
    send(1, 8'h61, 1'b1);
    step(5);
    send(2, 8'h33, 1'b0);
    step(6);
    check("ovr_none_yet", overrun, 0);
    send(2, 8'h44, 1'b1);
    step(6);
    check("ovr_flag", overrun, 32'h4);
    out_ready = 1'b1;
    step(1);
    check("ovr_survivor", out_data, 32'h44);
    step(1);
    check("ovr_idle", out_valid, 0);
    check("ovr_ack_level", src_ack[2], src_toggle[2]);
    check("ovr_ack", src_ack, 32'h4);
    check("ovr_sticky", overrun, 32'h4);
    overrun_clr = 1'b1;
    step(1);
    overrun_clr = 1'b0;
    check("ovr_clear", overrun, 0);

    // Random soak with protocol-obeying sources and random ready
    for (int t = 0; t < 600; t++) begin
      out_ready = 1'($urandom_range(0, 1));
      for (int c = 0; c < CH; c++) begin
        if (src_ack[c] == src_toggle[c] && $urandom_range(0, 2) == 0)
          send(c, W'($urandom_range(0, 255)), 1'b1);
      end
      step(1);
    end
    out_ready = 1'b1;
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) step(1);
    step(2);
    check("soak_drained", exp_q.size(), 0);
    check("soak_overrun", overrun, 0);
    check("soak_ack", src_ack, src_toggle);
    check("soak_idle", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
